debounce_scheduler: RTL and testbench
=====================================

// Module: debounce_scheduler
// PURPOSE
//  - Debounces N_SW switch inputs using one shared lockout counter instead of one per channel.
//  - A round-robin arbiter picks one changed channel at a time:
//    - the grant transfers that channel's new level to its output;
//    - the channel then holds the counter for the lockout window.
//  - Sits between board switches (already synchronised to clk) and user logic.
//  - Replaces a bank of per-switch debouncers when counter area matters.
// PARAMETERS
//  N_SW       4   number of switch channels (2..16)
//  DELAY_CNT  3   counter reload value; lockout lasts DELAY_CNT+1 cycles in DELAY
//  CNT_W      2   counter width; must satisfy 2**CNT_W > DELAY_CNT
// PORTS
//  clk        in   1            system clock, all logic on posedge
//  rst        in   1            synchronous, active-high reset
//  sw         in   N_SW         raw switch levels, already synchronous to clk
//  out        out  N_SW         debounced levels
//  out_chg    out  N_SW         one-cycle pulse on the bit whose out changed
//  busy       out  1            1 while the shared counter is owned (state DELAY)
//  grant_idx  out  $clog2(N_SW) channel owning / last owning the counter
// BEHAVIOUR
//  - Reset (rst=1 at posedge): clears all outputs and state, takes priority over everything.
//    - out=0, out_chg=0, busy=0, grant_idx=0.
//    - prev=0, rr_ptr=0, cnt=DELAY_CNT, state=TRANSFER.
//    - Reset mid-DELAY aborts the lockout immediately.
//  - Request: req[i] = (sw[i] != prev[i]), combinational, not sticky.
//    - A glitch that returns to prev before it is granted is dropped; this is intended filtering.
//  - TRANSFER, any req set:
//    - g = first requesting channel at or above rr_ptr, wrapping modulo N_SW.
//    - On that edge: prev[g]<=sw[g], out[g]<=sw[g], out_chg[g]<=1, grant_idx<=g.
//    - Also on that edge: cnt<=DELAY_CNT, state<=DELAY.
//  - TRANSFER, no req: nothing changes; out_chg<=0.
//  - DELAY:
//    - out_chg<=0. All out bits hold, granted channel included. sw is ignored for channel g.
//    - Every channel may raise req, but none is granted.
//    - cnt!=0: cnt<=cnt-1.
//    - cnt==0: state<=TRANSFER, rr_ptr<=(g+1) mod N_SW.
//  - Latency:
//    - Change seen in TRANSFER: out updates at the same sampling edge (1 register stage).
//    - After a grant at edge k: next grant possible at edge k+DELAY_CNT+2 at the earliest.
//  - Fairness: all N_SW channels changing together are served in rotation from rr_ptr.
//    - Worst-case wait is (N_SW-1)*(DELAY_CNT+2) cycles.
//  - Simultaneous events:
//    - Several req in one cycle: only g is served; the others remain requesting.
//    - sw[g] toggling during its own lockout is ignored.
//    - If sw[g] still differs from prev[g] at return to TRANSFER, it re-requests normally.
//  - Only one out_chg bit can be high in any cycle.
//  - busy = (state==DELAY), registered.
//  - Unused state encoding: recover to TRANSFER with reset values (default branch).
// STRUCTURE
//  - Package debounce_pkg holds:
//    - state encoding: TRANSFER=1'b1, DELAY=1'b0;
//    - defaults DELAY_CNT_DEF=3 and N_SW_DEF=4;
//    - a clog2 helper function.
//  - Sub-module rr_arbiter, purely combinational:
//    - inputs req[N_SW] and ptr;
//    - outputs gnt_vld and gnt_idx (first set bit at or above ptr, with wrap).
//  - Top level holds the FSM, counter, prev/out registers and rr_ptr.
// TESTING
//  - Reset:
//    - Stimulus: rst=1 for 2 cycles with sw=4'b1111.
//    - Response: out=0, busy=0, out_chg=0, grant_idx=0.
//    - Then: first grant at the first edge after rst falls, to ch0.
//  - Single press:
//    - Stimulus: sw 0000->0001 at edge k.
//    - Response at k: out=0001, out_chg=0001, busy=1 from k.
//    - Response after: busy drops after edge k+4, with DELAY_CNT=3.
//  - Bounce:
//    - Stimulus: ch0 toggles 1/0/1 on cycles k+1..k+3.
//    - Response: out[0] stays 1, no further out_chg, busy ends on schedule.
//  - Contention:
//    - Stimulus: sw 0000->1111 at once.
//    - Response: grants ch0,1,2,3 at edges k, k+5, k+10, k+15; grant_idx follows.
//  - Round-robin wrap:
//    - Stimulus: after serving ch3, raise ch2 and ch0 together.
//    - Response: ch0 is granted first (rr_ptr=0), then ch2.
//  - Mid-lockout reset and dropped glitch:
//    - Stimulus: rst=1 during DELAY.
//    - Response: busy=0 and out=0 the next cycle.
//    - Stimulus: ch1 pulses for 2 cycles while ch0 holds the counter.
//    - Response: ch1 is never granted; out[1] stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the shared-counter switch debouncer.
// Holds the FSM encoding, default parameter values and a width helper.
// Imported by the arbiter and the top level.
package debounce_pkg;

  // TRANSFER: waiting for a changed channel; DELAY: shared counter owned
  typedef enum logic {
    DELAY    = 1'b0,
    TRANSFER = 1'b1
  } state_t;

  localparam int DELAY_CNT_DEF = 3;
  localparam int N_SW_DEF      = 4;

  // Index width for a value range of 'value' entries, never below one bit
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    if (res == 0) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// Round-robin pick of one requesting channel, purely combinational.
// Zero latency: gnt_idx is the first set req bit at or above ptr, wrapping.
// No backpressure; gnt_vld is low when no channel requests.
module rr_arbiter
  import debounce_pkg::*;
#(
  parameter int N_SW = N_SW_DEF
) (
  input  logic [N_SW-1:0]        req,
  input  logic [clog2(N_SW)-1:0] ptr,
  output logic                   gnt_vld,
  output logic [clog2(N_SW)-1:0] gnt_idx
);

  localparam int IDX_W = clog2(N_SW);

  // Scan from the farthest offset down so the closest requester to ptr wins
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] sel;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    sel     = '0;
    for (int off = N_SW - 1; off >= 0; off--) begin
      pos = int'(ptr) + off;
      if (pos >= N_SW) begin
        pos = pos - N_SW;
      end
      sel = IDX_W'(pos);
      if (req[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces N_SW synchronised switches with one shared lockout counter.
// Latency: one register stage from a granted change to out/out_chg.
// No backpressure; ungranted changes keep requesting while they persist.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_SW      = N_SW_DEF,
  parameter int DELAY_CNT = DELAY_CNT_DEF,
  parameter int CNT_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SW-1:0]        sw,
  output logic [N_SW-1:0]        out,
  output logic [N_SW-1:0]        out_chg,
  output logic                   busy,
  output logic [clog2(N_SW)-1:0] grant_idx
);

  localparam int               IDX_W      = clog2(N_SW);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DELAY_CNT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SW-1:0]    prev_q, prev_d;
  logic [N_SW-1:0]    out_q, out_d;
  logic [N_SW-1:0]    out_chg_q, out_chg_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [N_SW-1:0]    req;
  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;

  // A channel requests only while its level differs from the last accepted one,
  // so a glitch that returns before being granted simply disappears.
  assign req = sw ^ prev_q;

  rr_arbiter #(
    .N_SW(N_SW)
  ) u_arb (
    .req    (req),
    .ptr    (rr_ptr_q),
    .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx)
  );

  // State register: all sequential state, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TRANSFER;
      cnt_q       <= CNT_RELOAD;
      prev_q      <= '0;
      out_q       <= '0;
      out_chg_q   <= '0;
      busy_q      <= 1'b0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      out_q       <= out_d;
      out_chg_q   <= out_chg_d;
      busy_q      <= busy_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Next-state logic: grant moves to DELAY, counter expiry returns to TRANSFER
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      TRANSFER: begin
        if (gnt_vld) begin
          state_d = DELAY;
          cnt_d   = CNT_RELOAD;
        end
      end
      DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = TRANSFER;
        end
      end
      default: begin
        state_d = TRANSFER;
        cnt_d   = CNT_RELOAD;
      end
    endcase
  end

  // Output/datapath logic: transfer the granted level, advance the RR pointer on release
  always_comb begin
    prev_d      = prev_q;
    out_d       = out_q;
    out_chg_d   = '0;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      TRANSFER: begin
        if (gnt_vld) begin
          prev_d[gnt_idx]    = sw[gnt_idx];
          out_d[gnt_idx]     = sw[gnt_idx];
          out_chg_d[gnt_idx] = 1'b1;
          grant_idx_d        = gnt_idx;
        end
      end
      DELAY: begin
        // The pointer moves past the owner only when the lockout ends, so a
        // channel kept busy by bounces cannot starve its neighbours.
        if (cnt_q == '0) begin
          if (int'(grant_idx_q) == N_SW - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        prev_d      = '0;
        out_d       = '0;
        grant_idx_d = '0;
        rr_ptr_d    = '0;
      end
    endcase
    busy_d = (state_d == DELAY);
  end

  assign out       = out_q;
  assign out_chg   = out_chg_q;
  assign busy      = busy_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler (N_SW=4, DELAY_CNT=3).
// Directed table and sequences plus random traffic against a reference model.
// Inputs change 1 ns after posedge, outputs are sampled at the same point.
module tb_debounce_scheduler;

  localparam int N  = 4;
  localparam int DC = 3;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] out;
  logic [3:0] out_chg;
  logic       busy;
  logic [1:0] grant_idx;

  int n_checks;
  int n_err;

  // Reference model: lockout expressed as edges still to run in lockout
  bit [3:0] m_prev;
  bit [3:0] m_out;
  bit [3:0] m_chg;
  int       m_lock;
  int       m_ptr;
  int       m_g;

  debounce_scheduler #(
    .N_SW     (N),
    .DELAY_CNT(DC),
    .CNT_W    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .out      (out),
    .out_chg  (out_chg),
    .busy     (busy),
    .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit [3:0] s);
    bit found;
    int c;
    if (r) begin
      m_prev = '0;
      m_out  = '0;
      m_chg  = '0;
      m_lock = 0;
      m_ptr  = 0;
      m_g    = 0;
    end else if (m_lock > 0) begin
      m_chg  = '0;
      m_lock = m_lock - 1;
      if (m_lock == 0) m_ptr = (m_g + 1) % N;
    end else begin
      m_chg = '0;
      found = 1'b0;
      for (int off = 0; off < N; off++) begin
        c = (m_ptr + off) % N;
        if (!found && (s[c] != m_prev[c])) begin
          found     = 1'b1;
          m_g       = c;
          m_prev[c] = s[c];
          m_out[c]  = s[c];
          m_chg[c]  = 1'b1;
          m_lock    = DC + 1;
        end
      end
    end
  endtask

  // One clock: drive, clock, advance model, compare DUT against model
  task automatic step(input bit r, input bit [3:0] s);
    rst = r;
    sw  = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    chk("model_out", int'(out), int'(m_out));
    chk("model_out_chg", int'(out_chg), int'(m_chg));
    chk("model_busy", int'(busy), int'(m_lock > 0));
    chk("model_grant_idx", int'(grant_idx), m_g);
  endtask

  task automatic expect_hand(input string tag, input bit [3:0] eo, input bit [3:0] ec,
                             input bit eb, input int eg);
    chk({tag, "_out"}, int'(out), int'(eo));
    chk({tag, "_out_chg"}, int'(out_chg), int'(ec));
    chk({tag, "_busy"}, int'(busy), int'(eb));
    chk({tag, "_grant_idx"}, int'(grant_idx), eg);
  endtask

  typedef struct {
    bit       rst;
    bit [3:0] sw;
    bit [3:0] eout;
    bit [3:0] echg;
    bit       ebusy;
    int       eg;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit [3:0] s_cur;
    bit [3:0] e_out;
    bit [3:0] e_chg;
    int       e_g;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    sw       = 4'h0;
    m_prev   = '0;
    m_out    = '0;
    m_chg    = '0;
    m_lock   = 0;
    m_ptr    = 0;
    m_g      = 0;

    // Reset with switches high, first grant, lockout, single press with bounce
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 0};
    tbl[2]  = '{1'b0, 4'hF, 4'h1, 4'h1, 1'b1, 0};
    tbl[3]  = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b1, 0};
    tbl[4]  = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b1, 0};
    tbl[5]  = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b1, 0};
    tbl[6]  = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 0};
    tbl[7]  = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 0};
    tbl[8]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 0};
    tbl[9]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 0};
    tbl[10] = '{1'b0, 4'h1, 4'h1, 4'h1, 1'b1, 0};
    tbl[11] = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b1, 0};
    tbl[12] = '{1'b0, 4'h0, 4'h1, 4'h0, 1'b1, 0};
    tbl[13] = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b1, 0};
    tbl[14] = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 0};
    tbl[15] = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b0, 0};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].sw);
      expect_hand($sformatf("tbl%0d", i), tbl[i].eout, tbl[i].echg, tbl[i].ebusy, tbl[i].eg);
    end

    // Contention: all four change together, then wrap to ch0 before ch2
    step(1'b1, 4'h0);
    for (int e = 0; e < 30; e++) begin
      s_cur = (e < 20) ? 4'hF : 4'hA;
      step(1'b0, s_cur);
      if (e < 20) begin
        e_g   = e / 5;
        e_out = 4'((1 << (e_g + 1)) - 1);
      end else if (e < 25) begin
        e_g   = 0;
        e_out = 4'hE;
      end else begin
        e_g   = 2;
        e_out = 4'hA;
      end
      e_chg = ((e % 5) == 0) ? 4'(1 << e_g) : 4'h0;
      expect_hand($sformatf("cont%0d", e), e_out, e_chg, (e % 5) != 4, e_g);
    end

    // Glitch on ch1 while ch0 owns the counter is dropped
    step(1'b1, 4'h0);
    for (int j = 0; j < 9; j++) begin
      s_cur = (j == 1 || j == 2) ? 4'h3 : 4'h1;
      step(1'b0, s_cur);
      expect_hand($sformatf("glitch%0d", j), 4'h1, (j == 0) ? 4'h1 : 4'h0, j < 4, 0);
    end

    // Reset in the middle of a lockout clears busy and out at once
    step(1'b0, 4'h3);
    expect_hand("pre_rst", 4'h3, 4'h2, 1'b1, 1);
    step(1'b0, 4'h3);
    step(1'b1, 4'h3);
    expect_hand("mid_rst", 4'h0, 4'h0, 1'b0, 0);

    // Random traffic with occasional resets, checked against the model
    s_cur = 4'h0;
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) s_cur[b] = ~s_cur[b];
      end
      step($urandom_range(0, 199) == 0, s_cur);
      if ($countones(out_chg) > 1) begin
        chk("onehot_out_chg", $countones(out_chg), 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
